vga_timing: RTL

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It produces the sync outputs, the current pixel coordinate, the active-video flag, a per-line strobe, and the per-frame `frame_start` pulse. It sits upstream of `pong_game`, which advances its ball/paddle physics on `frame_start`, and alongside the pixel renderer, which consumes `pixel_x`, `pixel_y` and `video_active`.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_timing.sv | 84 ++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// Shared VGA screen geometry: default 640x480@60 timing and coordinate width.
// Imported by the timing generator, the renderer and pong_game.
package vga_pkg;

  localparam int unsigned COORD_W  = 10;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running h/v counters with a registered
// decode of sync, active-video, coordinates and line/frame strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_active,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so bounds equal to 2**COORD_W still compare correctly.
  localparam int unsigned CW = COORD_W + 1;
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST  = CW'(HT - 1);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST  = CW'(VT - 1);

  if (HT > (1 << COORD_W) || VT > (1 << COORD_W)) begin : g_bad_totals
    $error("vga_timing: H/V totals exceed the %0d-bit counter range", COORD_W);
  end

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic [CW-1:0]      h_ext, v_ext;
  logic               h_wrap, v_wrap;
  logic               hs_on, vs_on, act_d;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_wrap = (h_ext == H_LAST);
  assign v_wrap = (v_ext == V_LAST);
  assign hs_on  = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs_on  = (v_ext >= VS_BEG) && (v_ext < VS_END);
  assign act_d  = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      video_active <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;

      // Outputs reflect the pre-increment position, one clock behind the counters.
      pixel_x      <= h_cnt;
      pixel_y      <= v_cnt;
      video_active <= act_d;
      line_start   <= (h_cnt == '0);
      frame_start  <= (h_cnt == '0) && (v_ext == V_ACT_C);
      hsync        <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync        <= vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule
